nor_rd_ctrl: RTL and testbench

- Memory-mapped read controller for the external NOR flash.
- Turns a single bus read request (1/2/4 bytes) into one complete flash read transaction: CSB low, command, address, dummy, data, CSB high.
- Supports three wire modes, selected by the `mode` input:
  - SPI: 1-1-1 fast read.
  - DPI: 2-2-2.
  - QPI: 4-4-4.
- Sits between the SoC bus fabric and the nor_sck/nor_csb/nor_sio pads. Pad tristate is built from sio_oe/sio_o/sio_i.

---
 rtl/nor_rd_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_nor_rd_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_rd_ctrl.sv
// NOR flash memory-mapped read controller.
// Turns one bus read (1/2/4 bytes) into a complete flash fast-read transaction:
// CSB low, opcode, 24-bit address, dummy cycles, data, CSB high, guard time.
// SPI (1-1-1), DPI (2-2-2) and QPI (4-4-4) wire modes are supported.
module nor_rd_ctrl #(
  parameter int unsigned SCK_DIV = 1,
  parameter int unsigned CSB_HI  = 4,
  parameter logic [7:0]  CMD_SPI = 8'h0B,
  parameter logic [7:0]  CMD_DPI = 8'hBB,
  parameter logic [7:0]  CMD_QPI = 8'hEB
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  mode,
  input  logic        req,
  input  logic [23:0] addr,
  input  logic [1:0]  size,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        sck,
  output logic        csb,
  output logic [3:0]  sio_o,
  output logic [3:0]  sio_oe,
  input  logic [3:0]  sio_i
);

  localparam int unsigned DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int unsigned GRD_W = (CSB_HI > 1) ? $clog2(CSB_HI) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(CSB_HI - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GUARD} state_t;
  typedef enum logic [1:0] {W_SPI, W_DPI, W_QPI} wire_t;

  state_t            state_q;
  wire_t             wire_q, wire_new;
  logic [1:0]        size_q;
  logic [7:0]        cmd_new;
  logic [31:0]       tx_q, rx_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [GRD_W-1:0]  grd_cnt_q;
  logic [5:0]        bit_cnt_q, phase_len;
  logic              phase_end, tick;
  logic              sck_q, csb_q, busy_q, ready_q;
  logic [3:0]        sio_o_q, sio_oe_q;
  logic [31:0]       rdata_q;

  // Leading bits of a shift vector, placed on the lanes of the given mode.
  function automatic logic [3:0] lane_bits(wire_t w, logic [31:0] v);
    case (w)
      W_DPI:   return {2'b00, v[31:30]};
      W_QPI:   return v[31:28];
      default: return {3'b000, v[31]};
    endcase
  endfunction

  function automatic logic [31:0] shift_out(wire_t w, logic [31:0] v);
    case (w)
      W_DPI:   return {v[29:0], 2'b00};
      W_QPI:   return {v[27:0], 4'b0000};
      default: return {v[30:0], 1'b0};
    endcase
  endfunction

  // In SPI mode the flash answers on lane 1; wider modes use the low lanes.
  function automatic logic [31:0] shift_in(wire_t w, logic [31:0] v, logic [3:0] s);
    case (w)
      W_DPI:   return {v[29:0], s[1:0]};
      W_QPI:   return {v[27:0], s};
      default: return {v[30:0], s[1]};
    endcase
  endfunction

  function automatic logic [3:0] lane_oe(wire_t w);
    case (w)
      W_DPI:   return 4'b0011;
      W_QPI:   return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

  // Bytes arrive first-byte-first in the shift register; rdata wants the first byte lowest.
  function automatic logic [31:0] order_bytes(logic [1:0] sz, logic [31:0] v);
    case (sz)
      2'd0:    return {24'h0, v[7:0]};
      2'd1:    return {16'h0, v[7:0], v[15:8]};
      default: return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endcase
  endfunction

  // Decode the requested wire mode; mode 3 behaves as SPI.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wire_new = W_SPI;
    cmd_new  = CMD_SPI;
    case (mode)
      2'd1:    begin wire_new = W_DPI; cmd_new = CMD_DPI; end
      2'd2:    begin wire_new = W_QPI; cmd_new = CMD_QPI; end
      default: ;
    endcase
  end

  // Length of the current phase in sck cycles, and the end-of-phase / sck-toggle strobes.
  always_comb begin
    phase_len = 6'd1;
    case (state_q)
      S_CMD:   phase_len = (wire_q == W_QPI) ? 6'd2 : (wire_q == W_DPI) ? 6'd4 : 6'd8;
      S_ADDR:  phase_len = (wire_q == W_QPI) ? 6'd6 : (wire_q == W_DPI) ? 6'd12 : 6'd24;
      S_DUMMY: phase_len = (wire_q == W_QPI) ? 6'd10 : 6'd8;
      S_DATA: begin
        case (wire_q)
          W_QPI:   phase_len = (size_q == 2'd0) ? 6'd2 : (size_q == 2'd1) ? 6'd4 : 6'd8;
          W_DPI:   phase_len = (size_q == 2'd0) ? 6'd4 : (size_q == 2'd1) ? 6'd8 : 6'd16;
          default: phase_len = (size_q == 2'd0) ? 6'd8 : (size_q == 2'd1) ? 6'd16 : 6'd32;
        endcase
      end
      default: phase_len = 6'd1;
    endcase
    phase_end = (bit_cnt_q == phase_len - 6'd1);
    tick      = (div_cnt_q == DIV_LAST);
  end

  // Transaction FSM with registered pad and bus outputs; reset aborts instantly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      wire_q    <= W_SPI;
      size_q    <= 2'd0;
      tx_q      <= '0;
      rx_q      <= '0;
      div_cnt_q <= '0;
      grd_cnt_q <= '0;
      bit_cnt_q <= '0;
      sck_q     <= 1'b0;
      csb_q     <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      sio_o_q   <= '0;
      sio_oe_q  <= '0;
      rdata_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            wire_q    <= wire_new;
            size_q    <= (size == 2'd3) ? 2'd2 : size;
            tx_q      <= shift_out(wire_new, {cmd_new, addr});
            sio_o_q   <= lane_bits(wire_new, {cmd_new, addr});
            sio_oe_q  <= lane_oe(wire_new);
            rx_q      <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sck_q     <= 1'b0;
            csb_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_CMD;
          end
        end
        S_GUARD: begin
          if (grd_cnt_q == GRD_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            grd_cnt_q <= grd_cnt_q + GRD_W'(1);
          end
        end
        default: begin
          if (!tick) begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end else begin
            div_cnt_q <= '0;
            if (!sck_q) begin
              // Rising edge: the flash samples our bits, we sample its data.
              sck_q <= 1'b1;
              if (state_q == S_DATA) rx_q <= shift_in(wire_q, rx_q, sio_i);
            end else begin
              // Falling edge: one sck cycle done; outputs may change now.
              sck_q     <= 1'b0;
              bit_cnt_q <= phase_end ? 6'd0 : bit_cnt_q + 6'd1;
              case (state_q)
                S_CMD, S_ADDR: begin
                  sio_o_q <= lane_bits(wire_q, tx_q);
                  tx_q    <= shift_out(wire_q, tx_q);
                  if (phase_end) state_q <= (state_q == S_CMD) ? S_ADDR : S_DUMMY;
                end
                S_DUMMY: begin
                  if (bit_cnt_q == 6'd0) begin
                    sio_oe_q <= '0;
                    sio_o_q  <= '0;
                  end
                  if (phase_end) state_q <= S_DATA;
                end
                default: begin
                  if (phase_end) begin
                    csb_q     <= 1'b1;
                    ready_q   <= 1'b1;
                    rdata_q   <= order_bytes(size_q, rx_q);
                    grd_cnt_q <= '0;
                    state_q   <= S_GUARD;
                  end
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign ready  = ready_q;
  assign rdata  = rdata_q;
  assign sck    = sck_q;
  assign csb    = csb_q;
  assign sio_o  = sio_o_q;
  assign sio_oe = sio_oe_q;

endmodule

// File: tb/tb_nor_rd_ctrl.sv
// Bench for nor_rd_ctrl: behavioural NOR flash model, directed reads with
// hand-computed results, and a scoreboard monitor checking every ready pulse.
module tb_nor_rd_ctrl;

  localparam int CSB_HI = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  mode, size;
  logic [23:0] addr;
  logic        req1, req3, sel3;
  logic [3:0]  sio_drv;

  logic        busy1, ready1, sck1, csb1, busy3, ready3, sck3, csb3;
  logic [31:0] rdata1, rdata3;
  logic [3:0]  sio_o1, oe1, sio_o3, oe3;

  always #5 clk = ~clk;

  nor_rd_ctrl #(.SCK_DIV(1), .CSB_HI(CSB_HI)) u_dut1 (
    .clk(clk), .rstn(rstn), .mode(mode), .req(req1), .addr(addr), .size(size),
    .busy(busy1), .ready(ready1), .rdata(rdata1), .sck(sck1), .csb(csb1),
    .sio_o(sio_o1), .sio_oe(oe1), .sio_i(sio_drv));

  nor_rd_ctrl #(.SCK_DIV(3), .CSB_HI(CSB_HI)) u_dut3 (
    .clk(clk), .rstn(rstn), .mode(mode), .req(req3), .addr(addr), .size(size),
    .busy(busy3), .ready(ready3), .rdata(rdata3), .sck(sck3), .csb(csb3),
    .sio_o(sio_o3), .sio_oe(oe3), .sio_i(sio_drv));

  // The flash model and monitor follow whichever controller is selected.
  logic        f_busy, f_ready, f_sck, f_csb;
  logic [31:0] f_rdata;
  logic [3:0]  f_sio_o, f_oe;
  assign f_busy  = sel3 ? busy3  : busy1;
  assign f_ready = sel3 ? ready3 : ready1;
  assign f_sck   = sel3 ? sck3   : sck1;
  assign f_csb   = sel3 ? csb3   : csb1;
  assign f_rdata = sel3 ? rdata3 : rdata1;
  assign f_sio_o = sel3 ? sio_o3 : sio_o1;
  assign f_oe    = sel3 ? oe3    : oe1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // ---------------- flash model ----------------
  logic [7:0]  mem [0:511];
  logic [1:0]  fm;
  int          rise_n;
  logic [7:0]  cmd_cap;
  logic [23:0] addr_cap;

  function automatic int lanes_of(logic [1:0] m);
    return (m == 2'd2) ? 4 : (m == 2'd1) ? 2 : 1;
  endfunction

  always @(negedge f_csb) begin
    rise_n   = 0;
    cmd_cap  = '0;
    addr_cap = '0;
  end

  always @(posedge f_sck) begin
    if (!f_csb) begin
      int l, c, a;
      logic [3:0] b;
      l = lanes_of(fm);
      c = 8 / l;
      a = 24 / l;
      b = (l == 4) ? f_sio_o : (l == 2) ? {2'b00, f_sio_o[1:0]} : {3'b000, f_sio_o[0]};
      rise_n++;
      if (rise_n <= c) cmd_cap = (cmd_cap << l) | {4'b0000, b};
      else if (rise_n <= c + a) addr_cap = (addr_cap << l) | {20'h0, b};
    end
  end

  always @(negedge f_sck) begin
    if (!f_csb) begin
      int l, c, a, d, k;
      logic [8:0] idx;
      logic [7:0] sh;
      l = lanes_of(fm);
      c = 8 / l;
      a = 24 / l;
      d = (l == 4) ? 10 : 8;
      if (rise_n >= c + a + d) begin
        k   = rise_n - (c + a + d);
        idx = addr_cap[8:0] + 9'((k * l) / 8);
        sh  = mem[idx] >> (8 - l - ((k * l) % 8));
        case (l)
          1:       sio_drv = {2'b00, sh[0], 1'b0};
          2:       sio_drv = {2'b00, sh[1:0]};
          default: sio_drv = sh[3:0];
        endcase
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  typedef struct { logic [31:0] rdata; int lat; } exp_t;
  exp_t exp_q[$];

  int   ncyc = 0, acc_cyc = 0, acc_cnt = 0, done_cnt = 0, last_ready_cyc = 0;
  int   csb_fall_cyc = 0, last_rise = -1, sck_falls = 0, oe_drop_fall = -1;
  logic busy_p = 1'b0, csb_p = 1'b1, sck_p = 1'b0, ready_p = 1'b0;
  logic [3:0] sio_p = '0, oe_p = '0, first_sio = '0, first_oe = '0;
  bit   b2b_armed = 1'b0;

  always @(negedge clk) begin
    int div_cur;
    exp_t e;
    div_cur = sel3 ? 3 : 1;
    ncyc++;
    if (f_busy && !busy_p) begin
      acc_cyc = ncyc;
      acc_cnt++;
    end
    if (!f_csb && csb_p) begin
      csb_fall_cyc = ncyc;
      first_sio    = f_sio_o;
      first_oe     = f_oe;
      sck_falls    = 0;
      oe_drop_fall = -1;
      last_rise    = -1;
      check("sck_low_at_csb_fall", 32'(f_sck), 32'd0);
      if (b2b_armed) check("b2b_csb_gap", 32'(ncyc - last_ready_cyc), 32'(CSB_HI + 1));
    end
    if (f_csb && !csb_p) check("sck_low_at_csb_rise", 32'(f_sck), 32'd0);
    if (!f_csb) begin
      if (f_sck && !sck_p) begin
        if (last_rise < 0) check("first_sck_rise", 32'(ncyc - csb_fall_cyc), 32'(div_cur));
        else check("sck_period", 32'(ncyc - last_rise), 32'(2 * div_cur));
        last_rise = ncyc;
      end
      if (!f_sck && sck_p) sck_falls++;
      if (f_oe == 4'b0000 && oe_p != 4'b0000 && oe_drop_fall < 0) oe_drop_fall = sck_falls;
    end
    if (f_sio_o != sio_p) check("sio_o_change_sck_low", 32'(f_sck), 32'd0);
    if (f_ready) begin
      check("ready_one_cycle", 32'(ready_p), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rdata", f_rdata, e.rdata);
        check("latency", 32'(ncyc - acc_cyc + 1), 32'(e.lat));
      end
      last_ready_cyc = ncyc;
      done_cnt++;
    end
    busy_p  = f_busy;
    csb_p   = f_csb;
    sck_p   = f_sck;
    ready_p = f_ready;
    sio_p   = f_sio_o;
    oe_p    = f_oe;
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n = 0;
    while (f_busy && n < 2000) begin @(negedge clk); n++; end
    if (f_busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 50) begin @(negedge clk); n++; end
    if (acc_cnt < target) check("accept_timeout", 32'(acc_cnt), 32'(target));
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 1000) begin @(negedge clk); n++; end
    if (done_cnt < target) check("ready_timeout", 32'(done_cnt), 32'(target));
  endtask

  task automatic issue(input bit s3, input logic [1:0] m, input logic [23:0] a, input logic [1:0] sz);
    int t;
    wait_idle();
    @(negedge clk);
    t = acc_cnt + 1;
    sel3 = s3; fm = m; mode = m; addr = a; size = sz;
    if (s3) req3 = 1'b1; else req1 = 1'b1;
    wait_acc(t);
    req1 = 1'b0;
    req3 = 1'b0;
    // Scramble the request inputs: the transaction must use the latched copies.
    mode = 2'($urandom);
    addr = 24'($urandom);
    size = 2'($urandom);
  endtask

  task automatic do_read(input bit s3, input logic [1:0] m, input logic [23:0] a,
                         input logic [1:0] sz, input logic [31:0] rd, input int lat);
    exp_t e;
    int   t;
    e.rdata = rd;
    e.lat   = lat;
    exp_q.push_back(e);
    t = done_cnt + 1;
    issue(s3, m, a, sz);
    wait_done(t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base_a, base_d;
    exp_t e;
    req1 = 1'b0; req3 = 1'b0; sel3 = 1'b0; fm = 2'd0;
    mode = 2'd0; addr = '0; size = 2'd0; sio_drv = '0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[5] = 8'hA5; mem[6] = 8'h5A;
    mem[9'h100] = 8'hC3; mem[9'h1FF] = 8'h9C;
    mem[9'h010] = 8'h01; mem[9'h011] = 8'h23; mem[9'h012] = 8'h45; mem[9'h013] = 8'h67;
    mem[9'h020] = 8'h7E; mem[9'h040] = 8'hB7; mem[9'h041] = 8'h5D;

    // Reset values on both controllers, in reset and just after release.
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_csb",   32'({csb1, csb3}),   32'd3);
    check("rst_sck",   32'({sck1, sck3}),   32'd0);
    check("rst_oe",    32'({oe1, oe3}),     32'd0);
    check("rst_sio_o", 32'({sio_o1, sio_o3}), 32'd0);
    check("rst_busy",  32'({busy1, busy3}), 32'd0);
    check("rst_ready", 32'({ready1, ready3}), 32'd0);
    check("rst_rdata", rdata1 | rdata3, 32'd0);
    #2 rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 32'({busy1, csb1, busy3, csb3}), 32'b0101);

    // SPI 4 bytes from 0.
    do_read(1'b0, 2'd0, 24'h000000, 2'd2, 32'h44332211, 1 + 2 * (8 + 24 + 8 + 32));
    check("spi_cmd", 32'(cmd_cap), 32'h0B);
    check("spi_addr", 32'(addr_cap), 32'h0);
    check("spi_first_oe", 32'(first_oe), 32'b0001);
    check("spi_first_sio", 32'(first_sio), 32'h0);

    // DPI 2 bytes from 5: 16 command/address sck cycles, oe drops on the 17th fall.
    do_read(1'b0, 2'd1, 24'h000005, 2'd1, 32'h00005AA5, 65);
    check("dpi_cmd", 32'(cmd_cap), 32'hBB);
    check("dpi_addr", 32'(addr_cap), 32'h5);
    check("dpi_first_oe", 32'(first_oe), 32'b0011);
    check("dpi_first_sio", 32'(first_sio), 32'h2);
    check("dpi_oe_drop_fall", 32'(oe_drop_fall), 32'd17);

    // QPI 1 byte from 0x100: 2+6+10+2 sck cycles.
    do_read(1'b0, 2'd2, 24'h000100, 2'd0, 32'h000000C3, 1 + 2 * (2 + 6 + 10 + 2));
    check("qpi_cmd", 32'(cmd_cap), 32'hEB);
    check("qpi_addr", 32'(addr_cap), 32'h100);
    check("qpi_first_oe", 32'(first_oe), 32'hF);
    check("qpi_first_sio", 32'(first_sio), 32'hE);
    check("qpi_oe_drop_fall", 32'(oe_drop_fall), 32'd9);

    // Mode 3 / size 3 aliases at the top address; address goes out unchanged.
    do_read(1'b0, 2'd3, 24'hFFFFFF, 2'd3, 32'h3322119C, 145);
    check("alias_cmd", 32'(cmd_cap), 32'h0B);
    check("alias_addr", 32'(addr_cap), 32'hFFFFFF);
    check("alias_first_oe", 32'(first_oe), 32'b0001);

    // Back-to-back with req held high: QPI 4B then DPI 1B.
    wait_idle();
    e.rdata = 32'h67452301; e.lat = 53; exp_q.push_back(e);
    e.rdata = 32'h0000007E; e.lat = 1 + 2 * (4 + 12 + 8 + 4); exp_q.push_back(e);
    base_a = acc_cnt;
    base_d = done_cnt;
    @(negedge clk);
    sel3 = 1'b0; fm = 2'd2; mode = 2'd2; addr = 24'h000010; size = 2'd2; req1 = 1'b1;
    wait_acc(base_a + 1);
    mode = 2'd1; addr = 24'h000020; size = 2'd0;
    wait_done(base_d + 1);
    fm = 2'd1;
    b2b_armed = 1'b1;
    wait_acc(base_a + 2);
    req1 = 1'b0;
    wait_done(base_d + 2);
    b2b_armed = 1'b0;
    check("b2b_ready_count", 32'(done_cnt - base_d), 32'd2);

    // Reset pulse during the address phase aborts with no ready pulse.
    issue(1'b0, 2'd0, 24'h000040, 2'd0);
    repeat (30) @(negedge clk);
    check("abort_in_addr", 32'(rise_n > 8 && rise_n <= 32 && !f_csb), 32'd1);
    base_d = done_cnt;
    #2 rstn = 1'b0;
    #1;
    check("abort_csb", 32'(csb1), 32'd1);
    check("abort_sck", 32'(sck1), 32'd0);
    check("abort_oe", 32'(oe1), 32'd0);
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_rdata", rdata1, 32'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    repeat (120) @(negedge clk);
    check("abort_no_ready", 32'(done_cnt - base_d), 32'd0);
    do_read(1'b0, 2'd0, 24'h000040, 2'd0, 32'h000000B7, 97);
    check("post_abort_addr", 32'(addr_cap), 32'h40);

    // SCK_DIV=3 controller: SPI 1 byte, 6-clk sck period.
    do_read(1'b1, 2'd0, 24'h000041, 2'd0, 32'h0000005D, 1 + 6 * 48);
    check("div3_cmd", 32'(cmd_cap), 32'h0B);
    check("div3_addr", 32'(addr_cap), 32'h41);
    check("div3_sck_low", 32'(sck3), 32'd0);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
